dds_cmd_seq: RTL and testbench

- Command sequencer that sits directly upstream of the DDS serial write engine (SPI to DDS) and feeds it one register command at a time.
- Buffers (address, 32-bit data) register writes/reads from the control logic in a FIFO, then issues them one by one:
  - presents the address and data to the engine;
  - pulses the engine's start input;
  - waits for the engine's done;
  - enforces an inter-command gap.
- Captures read-back words for read commands and flags engine hangs via a timeout.

---
 rtl/dds_cmd_seq.sv | 122 ++++++++++++
 tb/tb_dds_cmd_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_cmd_seq.sv
// dds_cmd_seq: queues DDS register commands and issues them one at a time to the serial write engine
module dds_cmd_seq #(
  parameter int DEPTH      = 16,
  parameter int START_W    = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_addr,
  input  logic [31:0]                push_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic                       cmd_start,
  output logic [7:0]                 cmd_addr,
  output logic [31:0]                cmd_din,
  input  logic                       cmd_done,
  input  logic [31:0]                cmd_dout,
  output logic                       rb_valid,
  output logic [7:0]                 rb_addr,
  output logic [31:0]                rb_data,
  output logic                       ovf,
  output logic                       timeout_err,
  input  logic                       err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int M1 = TIMEOUT > START_W ? TIMEOUT : START_W;
  localparam int CM = M1 > GAP_CYCLES ? M1 : GAP_CYCLES;
  localparam int CW = $clog2(CM + 1);
  localparam int GL = GAP_CYCLES > 1 ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_LOW, WAIT_DONE, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [39:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_n;
  logic            push_ok, pop, tout, start_n, rb_n;

  assign push_ok = push & ~full;
  assign level_n = level + LW'(push_ok) - LW'(pop);

  // state register plus a per-state cycle counter that restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  // next-state selection
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = level != '0 ? LOAD : IDLE;
      LOAD:      state_n = START;
      START:     state_n = cnt == CW'(START_W) ? WAIT_LOW : START;
      WAIT_LOW:  state_n = !cmd_done ? WAIT_DONE : tout ? GAP : WAIT_LOW;
      WAIT_DONE: state_n = (cmd_done || tout) ? GAP : WAIT_DONE;
      GAP:       state_n = cnt == CW'(GL) ? IDLE : GAP;
      default:   state_n = IDLE;
    endcase
  end

  // per-state decodes: pop, timeout, start request and read-back capture
  always_comb begin
    busy    = state != IDLE;
    pop     = state == LOAD;
    tout    = ((state == WAIT_LOW && cmd_done) || (state == WAIT_DONE && !cmd_done)) && cnt == CW'(TIMEOUT - 1);
    start_n = state == START && cnt != CW'(START_W);
    rb_n    = state == WAIT_DONE && cmd_done && cmd_addr[7];
  end

  // command storage; contents need no reset because pointers and level gate every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_addr, push_data};
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level  <= level_n;
      full   <= level_n == LW'(DEPTH);
      ovf    <= err_clr ? 1'b0 : (ovf | (push & full));
    end
  end

  // engine-facing registers, read-back capture and timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_start   <= 1'b0;
      cmd_addr    <= '0;
      cmd_din     <= '0;
      rb_valid    <= 1'b0;
      rb_addr     <= '0;
      rb_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      cmd_start   <= start_n;
      {cmd_addr, cmd_din} <= pop ? mem[rd_ptr] : {cmd_addr, cmd_din};
      rb_valid    <= rb_n;
      rb_addr     <= rb_n ? cmd_addr : rb_addr;
      rb_data     <= rb_n ? cmd_dout : rb_data;
      timeout_err <= err_clr ? 1'b0 : (timeout_err | tout);
    end
  end
endmodule

// File: tb/tb_dds_cmd_seq.sv
// tb_dds_cmd_seq: directed, table-driven and randomized checks of dds_cmd_seq against a queue-based model
module tb_dds_cmd_seq;
  localparam int DEPTH = 16, START_W = 2, GAP_CYCLES = 4, TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst, push, full, busy, cmd_start, cmd_done, rb_valid, ovf, timeout_err, err_clr;
  logic [7:0] push_addr, cmd_addr, rb_addr;
  logic [31:0] push_data, cmd_din, cmd_dout, rb_data;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  dds_cmd_seq #(.DEPTH(DEPTH), .START_W(START_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_data(push_data),
    .full(full), .level(level), .busy(busy), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
    .cmd_din(cmd_din), .cmd_done(cmd_done), .cmd_dout(cmd_dout), .rb_valid(rb_valid),
    .rb_addr(rb_addr), .rb_data(rb_data), .ovf(ovf), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  typedef struct {
    logic       push;
    logic [7:0] addr;
    logic       clr;
    logic       acc;
    int         lvl;
    logic       full;
    logic       ovf;
  } vec_t;

  vec_t        tbl [21];
  int          n_chk = 0, n_fail = 0;
  logic [39:0] exp_q [$];
  logic [39:0] rb_q [$];
  logic        prev_start = 0, prev_rb = 0, e_act = 0, stall = 0, hang = 0, use_fix = 0, done_rose = 0;
  logic [7:0]  cur_addr = 0;
  logic [31:0] fix_dout = 0;
  int          slen = 0, e_cnt = 0, lat = 2, fix_lat = 0, n_start = 0, n_rb = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // engine model: drops done one cycle after start is seen, raises it lat cycles later
  task automatic engine();
    done_rose = 0;
    if (rst) begin
      e_act = 0;
      cmd_done = 1;
    end else if (hang) cmd_done = 1;
    else if (!e_act && cmd_start) begin
      e_act = 1;
      e_cnt = 0;
      lat = fix_lat > 0 ? fix_lat : $urandom_range(2, 30);
    end else if (e_act) begin
      e_cnt++;
      if (e_cnt == 1) cmd_done = 0;
      else if (!stall && e_cnt >= 1 + lat) begin
        cmd_done = 1;
        cmd_dout = use_fix ? fix_dout : $urandom;
        if (cur_addr[7]) rb_q.push_back({cur_addr, cmd_dout});
        e_act = 0;
        done_rose = 1;
      end
    end
  endtask

  task automatic monitor();
    logic [39:0] t;
    if (cmd_start && !prev_start) begin
      n_start++;
      chk("start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        chk("cmd_order", {cmd_addr, cmd_din}, t);
        cur_addr = t[39:32];
        chk("level_at_start", level, exp_q.size());
      end
      slen = 0;
    end
    if (cmd_start) begin
      slen++;
      chk("start_busy", busy, 1);
    end
    if (!cmd_start && prev_start) chk("start_len", slen, START_W);
    if (rb_valid) begin
      n_rb++;
      chk("rb_pulse", prev_rb, 0);
      chk("rb_expected", rb_q.size() != 0, 1);
      if (rb_q.size() != 0) begin
        t = rb_q.pop_front();
        chk("rb_word", {rb_addr, rb_data}, t);
      end
    end
    prev_start = cmd_start;
    prev_rb = rb_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    engine();
    @(negedge clk);
    monitor();
  endtask

  task automatic do_push(input logic [7:0] a, input logic [31:0] d, input logic acc);
    push = 1;
    push_addr = a;
    push_data = d;
    if (acc) exp_q.push_back({a, d});
    step();
    push = 0;
  endtask

  task automatic drain(input string nm, input int lim);
    int k = 0;
    do begin
      step();
      k++;
    end while ((busy || exp_q.size() != 0) && k < lim);
    chk(nm, {busy, 32'(exp_q.size())}, 0);
  endtask

  initial begin
    int n, s0, r0;
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(i), 1'b0, 1'b1, i + 1, i == 15, 1'b0};
    tbl[16] = '{1'b1, 8'h10, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 8'h11, 1'b1, 1'b0, 16, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 8'h12, 1'b0, 1'b0, 16, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0};
    rst = 1; push = 0; push_addr = 0; push_data = 0; err_clr = 0; cmd_done = 1; cmd_dout = 0;
    repeat (3) step();
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", cmd_start, 0);
    chk("rst_cmd", {cmd_addr, cmd_din}, 0);
    chk("rst_rb", {rb_valid, rb_addr, rb_data}, 0);
    chk("rst_flags", {ovf, timeout_err}, 0);
    rst = 0;
    step();

    // single write: latency, hold, busy release
    fix_lat = 200;
    do_push(8'h01, 32'h0040_0820, 1);
    n = 0;
    while (!cmd_start && n < 10) begin step(); n++; end
    chk("latency", n, 3);
    n = 0;
    while (!done_rose && n < 400) begin step(); n++; end
    chk("done_seen", done_rose, 1);
    chk("hold_cmd", {cmd_addr, cmd_din}, {8'h01, 32'h0040_0820});
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("busy_fall", n, 5);
    chk("no_rb_write", n_rb, 0);
    fix_lat = 0;

    // read-back
    use_fix = 1;
    fix_dout = 32'hDEAD_BEEF;
    r0 = n_rb;
    do_push(8'h8E, $urandom, 1);
    drain("rb_drain", 300);
    chk("rb_count", n_rb - r0, 1);
    chk("rb_final", {rb_addr, rb_data}, {8'h8E, 32'hDEAD_BEEF});
    use_fix = 0;

    // push/pop collision at level 1
    s0 = n_start;
    do_push(8'h41, 32'h1111_0000, 1);
    step();
    do_push(8'h42, 32'h2222_0000, 1);
    chk("collision_level", level, 1);
    drain("collision_drain", 300);
    chk("collision_starts", n_start - s0, 2);

    // burst into a stalled engine, table-driven
    stall = 1;
    do_push(8'h20, 32'h2020_2020, 1);
    repeat (8) step();
    for (int i = 0; i < 21; i++) begin
      push = tbl[i].push;
      push_addr = tbl[i].addr;
      push_data = {24'hA5A5_00, tbl[i].addr};
      err_clr = tbl[i].clr;
      if (tbl[i].push && tbl[i].acc) exp_q.push_back({push_addr, push_data});
      step();
      push = 0;
      err_clr = 0;
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
    end
    stall = 0;
    drain("burst_drain", 3000);
    chk("burst_level", {full, level}, 0);

    // timeout with done stuck high
    hang = 1;
    r0 = n_rb;
    do_push(8'h30, 32'h3030_3030, 1);
    do_push(8'h85, 32'h8585_8585, 1);
    n = 0;
    while (!cmd_start && n < 20) begin step(); n++; end
    while (cmd_start && n < 40) begin step(); n++; end
    n = 0;
    while (!timeout_err && n < 5000) begin step(); n++; end
    chk("timeout_cycles", n, TIMEOUT);
    drain("timeout_drain", 6000);
    chk("timeout_sticky", timeout_err, 1);
    chk("timeout_no_rb", n_rb - r0, 0);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("timeout_clr", timeout_err, 0);
    hang = 0;

    // reset in WAIT_DONE with three queued
    stall = 1;
    for (int i = 0; i < 4; i++) do_push(8'(8'h50 + i), $urandom, 1);
    repeat (6) step();
    chk("pre_rst_level", level, 3);
    rst = 1;
    step();
    chk("mid_rst", {cmd_start, level, busy}, 0);
    rst = 0;
    exp_q.delete();
    stall = 0;
    s0 = n_start;
    repeat (50) step();
    chk("no_start_after_rst", n_start - s0, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (exp_q.size() < DEPTH - 2 && $urandom_range(0, 3) == 0) do_push(8'($urandom), $urandom, 1);
      else step();
    end
    drain("rand_drain", 4000);
    chk("rand_rb_left", rb_q.size(), 0);
    chk("rand_flags", {ovf, timeout_err, full, level}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
